// File: rtl/timer_pkg.sv
// Shared timer/counter definitions.
//   tmr_state_t : countdown_timer FSM states
//   cnt_w()     : count width for a given maximum count, shared with counter
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_RUN,
    TMR_DONE
  } tmr_state_t;

  // Width able to hold 0..max_count inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter: counts a programmed interval to zero and pulses
// expired for one cycle, in one-shot or periodic (auto-reload) mode.
//
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   load       in  load request, accepted when load && load_ready
//   load_value in  interval in cycles, clamped to MAX_COUNT
//   periodic   in  mode captured with an accepted load (1 = auto-reload)
//   enable     in  count-down qualifier
//   abort      in  cancel interval, return to idle
//   load_ready out not running and not aborting
//   busy       out high while counting
//   expired    out one-cycle expiry pulse
//   count      out remaining count
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned  MAX_COUNT = 256,
  localparam int unsigned W         = cnt_w(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         periodic,
  input  logic         enable,
  input  logic         abort,
  output logic         load_ready,
  output logic         busy,
  output logic         expired,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MaxVal = W'(MAX_COUNT);

  tmr_state_t   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;

  logic [W-1:0] clamped;
  logic         load_ok;

  assign clamped    = (load_value > MaxVal) ? MaxVal : load_value;
  assign load_ready = (state_q != TMR_RUN) && !abort;
  // A zero interval is accepted but has no effect.
  assign load_ok    = load && load_ready && (load_value != '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;

    if (abort) begin
      state_d = TMR_IDLE;
      count_d = '0;
    end else if (load_ok) begin
      // Also taken from DONE, where it overrides the reload/idle decision.
      state_d  = TMR_RUN;
      count_d  = clamped;
      reload_d = clamped;
      mode_d   = periodic;
    end else begin
      unique case (state_q)
        TMR_IDLE: ;
        TMR_RUN: begin
          if (enable) begin
            if (count_q == W'(1)) begin
              count_d = '0;
              state_d = TMR_DONE;
            end else begin
              count_d = count_q - W'(1);
            end
          end
        end
        TMR_DONE: begin
          if (mode_q) begin
            count_d = reload_q;
            state_d = TMR_RUN;
          end else begin
            state_d = TMR_IDLE;
          end
        end
        default: begin
          state_d = TMR_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TMR_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
    end
  end

  assign busy    = (state_q == TMR_RUN);
  assign expired = (state_q == TMR_DONE);
  assign count   = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  // Small instance (MAX_COUNT = 8, W = 4) carries most of the checks.
  logic       clk = 1'b0;
  logic       rst;
  logic       load, periodic, enable, abort;
  logic [3:0] load_value;
  logic       load_ready, busy, expired;
  logic [3:0] count;

  // Full-size instance (MAX_COUNT = 256, W = 9) for the largest interval.
  logic       b_load;
  logic [8:0] b_value;
  logic       b_periodic, b_enable, b_abort;
  logic       b_ready, b_busy, b_expired;
  logic [8:0] b_count;

  int tests = 0;
  int failures = 0;

  // Reference model: remaining cycles, running/firing flags, stored interval and mode.
  int m_rem, m_rel;
  bit m_run, m_fire, m_per;

  countdown_timer #(.MAX_COUNT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .periodic   (periodic),
    .enable     (enable),
    .abort      (abort),
    .load_ready (load_ready),
    .busy       (busy),
    .expired    (expired),
    .count      (count)
  );

  countdown_timer #(.MAX_COUNT(256)) dut_big (
    .clk        (clk),
    .rst        (rst),
    .load       (b_load),
    .load_value (b_value),
    .periodic   (b_periodic),
    .enable     (b_enable),
    .abort      (b_abort),
    .load_ready (b_ready),
    .busy       (b_busy),
    .expired    (b_expired),
    .count      (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int v;
    if (rst) begin
      m_rem = 0; m_rel = 0; m_run = 0; m_fire = 0; m_per = 0;
    end else if (abort) begin
      m_run = 0; m_fire = 0; m_rem = 0;
    end else if (!m_run && load && load_value != 0) begin
      v = (int'(load_value) > 8) ? 8 : int'(load_value);
      m_rem = v; m_rel = v; m_per = periodic; m_run = 1; m_fire = 0;
    end else if (m_run) begin
      if (enable) begin
        if (m_rem == 1) begin
          m_rem = 0; m_run = 0; m_fire = 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end else if (m_fire) begin
      m_fire = 0;
      if (m_per) begin
        m_rem = m_rel; m_run = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},      32'(count),      32'(m_rem));
    check({tag, ".busy"},       32'(busy),       32'(m_run));
    check({tag, ".expired"},    32'(expired),    32'(m_fire));
    check({tag, ".load_ready"}, 32'(load_ready), 32'(!m_run && !abort));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load = 0; load_value = 0; periodic = 0; enable = 0; abort = 0; rst = 0;
  endtask

  initial begin
    int pulses;
    int n;
    idle_inputs();
    b_load = 0; b_value = 0; b_periodic = 0; b_enable = 1; b_abort = 0;

    // Reset
    rst = 1;
    tick("reset");
    tick("reset");
    rst = 0;
    #1;
    check("reset.count", 32'(count), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.ready", 32'(load_ready), 1);

    // One-shot V=3
    load = 1; load_value = 4'd3; periodic = 0; enable = 1;
    tick("oneshot_load");
    load = 0;
    check("oneshot.first", 32'(count), 3);
    for (int i = 0; i < 3; i++) tick("oneshot");
    check("oneshot.pulse", 32'(expired), 1);
    tick("oneshot_after");
    check("oneshot.idle", 32'(busy), 0);
    check("oneshot.nopulse", 32'(expired), 0);

    // Periodic V=4 for 20 cycles
    load = 1; load_value = 4'd4; periodic = 1; enable = 1;
    tick("periodic_load");
    load = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick("periodic");
      if (expired) pulses++;
    end
    check("periodic.pulses", 32'(pulses), 4);
    abort = 1;
    tick("periodic_abort");
    abort = 0;

    // Zero load ignored
    load = 1; load_value = 4'd0;
    tick("zero_load");
    load = 0;
    check("zero_load.busy", 32'(busy), 0);

    // Clamp 12 -> 8
    load = 1; load_value = 4'd12; periodic = 0; enable = 1;
    tick("clamp_load");
    load = 0;
    check("clamp.count", 32'(count), 8);
    for (int i = 0; i < 9; i++) tick("clamp_run");

    // Enable gating V=5, pattern 1,0,0,1,...
    load = 1; load_value = 4'd5; periodic = 0; enable = 0;
    tick("gate_load");
    load = 0;
    n = 0;
    for (int i = 0; i < 40 && !expired; i++) begin
      enable = (i % 3 == 0);
      if (enable) n++;
      tick("gate");
    end
    enable = 0;
    check("gate.enabled_cycles", 32'(n), 5);
    tick("gate_after");

    // Abort at count=2
    load = 1; load_value = 4'd4; periodic = 1; enable = 1;
    tick("abort_load");
    load = 0;
    for (int i = 0; i < 10 && m_rem != 2; i++) tick("abort_run");
    abort = 1;
    tick("abort_hit");
    abort = 0;
    check("abort.count", 32'(count), 0);
    check("abort.busy", 32'(busy), 0);
    tick("abort_after");
    check("abort.nopulse", 32'(expired), 0);

    // Abort coincident with load in idle
    abort = 1; load = 1; load_value = 4'd5;
    #1;
    check("abort_load.ready", 32'(load_ready), 0);
    tick("abort_load_idle");
    abort = 0; load = 0;
    check("abort_load.busy", 32'(busy), 0);

    // Reset at count=2
    load = 1; load_value = 4'd6; periodic = 1; enable = 1;
    tick("rst_load");
    load = 0;
    for (int i = 0; i < 10 && m_rem != 2; i++) tick("rst_run");
    rst = 1;
    tick("rst_hit");
    rst = 0;
    check("rst.count", 32'(count), 0);
    tick("rst_after");
    check("rst.nopulse", 32'(expired), 0);

    // Load during DONE
    load = 1; load_value = 4'd3; periodic = 1; enable = 1;
    tick("done_load1");
    load = 0;
    for (int i = 0; i < 3; i++) tick("done_run");
    check("done.pulse", 32'(expired), 1);
    load = 1; load_value = 4'd6; periodic = 0;
    tick("done_load2");
    load = 0;
    check("done.newcount", 32'(count), 6);
    for (int i = 0; i < 6; i++) tick("done_run2");
    check("done.expire2", 32'(expired), 1);
    tick("done_oneshot");
    check("done.oneshot_idle", 32'(busy), 0);

    // Randomized
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      load       = ($urandom_range(0, 3) == 0);
      load_value = 4'($urandom_range(0, 15));
      periodic   = 1'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      tick("random");
    end
    idle_inputs();
    rst = 1;
    tick("random_end");
    rst = 0;

    // Full-size interval 256
    b_load = 1; b_value = 9'd256;
    tick("big_load");
    b_load = 0;
    check("big.count", 32'(b_count), 256);
    check("big.busy", 32'(b_busy), 1);
    n = 0;
    for (int i = 0; i < 300 && !b_expired; i++) begin
      tick("big_run");
      n++;
    end
    check("big.cycles", 32'(n), 256);
    check("big.pulse", 32'(b_expired), 1);
    tick("big_after");
    check("big.idle", 32'(b_busy), 0);
    check("big.nopulse", 32'(b_expired), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
